// File: rtl/cache_port_arbiter.sv
// ============================================================================
// cache_port_arbiter : round-robin sequencer sharing one cache port between
//                      instruction fetch (port 0) and load/store (port 1)
// Revision 1.0
// ============================================================================
`default_nettype none

module cache_port_arbiter #(
   parameter int ADDR_W   = 10,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              p0_valid,
   input  logic [ADDR_W-1:0] p0_addr,
   output logic              p0_ack,
   output logic [DATA_W-1:0] p0_rdata,
   output logic              p0_err,
   input  logic              p1_valid,
   input  logic              p1_we,
   input  logic [1:0]        p1_storetype,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p1_wdata,
   output logic              p1_ack,
   output logic [DATA_W-1:0] p1_rdata,
   output logic              p1_err,
   output logic              m_read,
   output logic              m_write,
   output logic [1:0]        m_storetype,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   input  logic              m_stall,
   input  logic [DATA_W-1:0] m_rdata,
   output logic              busy,
   output logic              timeout_flag
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;
   localparam logic [7:0] C_WAIT_LAST = 8'(MAX_WAIT - 1);

   logic [1:0]        state_q,      state_d;
   logic              last_grant_q, last_grant_d;
   logic              grant_q,      grant_d;
   logic              we_q,         we_d;
   logic [1:0]        storetype_q,  storetype_d;
   logic [ADDR_W-1:0] addr_q,       addr_d;
   logic [DATA_W-1:0] wdata_q,      wdata_d;
   logic [7:0]        wait_cnt_q,   wait_cnt_d;
   logic              err_q,        err_d;
   logic              timeout_q,    timeout_d;
   logic [DATA_W-1:0] p0_rdata_q,   p0_rdata_d;
   logic [DATA_W-1:0] p1_rdata_q,   p1_rdata_d;

   // last_grant resets to port 1 so port 0 wins the first tie
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         last_grant_q <= 1'b1;
         grant_q      <= 1'b0;
         we_q         <= 1'b0;
         storetype_q  <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         wait_cnt_q   <= '0;
         err_q        <= 1'b0;
         timeout_q    <= 1'b0;
         p0_rdata_q   <= '0;
         p1_rdata_q   <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         grant_q      <= grant_d;
         we_q         <= we_d;
         storetype_q  <= storetype_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         wait_cnt_q   <= wait_cnt_d;
         err_q        <= err_d;
         timeout_q    <= timeout_d;
         p0_rdata_q   <= p0_rdata_d;
         p1_rdata_q   <= p1_rdata_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      grant_d      = grant_q;
      we_d         = we_q;
      storetype_d  = storetype_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      wait_cnt_d   = wait_cnt_q;
      err_d        = err_q;
      timeout_d    = timeout_q;
      p0_rdata_d   = p0_rdata_q;
      p1_rdata_d   = p1_rdata_q;
      unique case (state_q)
         S_IDLE: begin
            if (p0_valid || p1_valid) begin
               grant_d      = (p0_valid && p1_valid) ? ~last_grant_q : p1_valid;
               last_grant_d = grant_d;
               wait_cnt_d   = '0;
               state_d      = S_BUSY;
               if (grant_d) begin
                  we_d        = p1_we;
                  storetype_d = p1_storetype;
                  addr_d      = p1_addr;
                  wdata_d     = p1_wdata;
               end else begin
                  we_d        = 1'b0;
                  storetype_d = '0;
                  addr_d      = p0_addr;
                  wdata_d     = '0;
               end
            end
         end
         S_BUSY: begin
            if (!m_stall) begin
               if (!we_q) begin
                  if (grant_q) p1_rdata_d = m_rdata;
                  else         p0_rdata_d = m_rdata;
               end
               err_d   = 1'b0;
               state_d = S_RESP;
            end else if (wait_cnt_q == C_WAIT_LAST) begin
               err_d     = 1'b1;
               timeout_d = 1'b1;
               state_d   = S_RESP;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs decode registered state only; nothing passes through from requesters
   always_comb begin
      m_read      = 1'b0;
      m_write     = 1'b0;
      m_storetype = '0;
      m_addr      = '0;
      m_wdata     = '0;
      p0_ack      = 1'b0;
      p0_err      = 1'b0;
      p1_ack      = 1'b0;
      p1_err      = 1'b0;
      unique case (state_q)
         S_BUSY: begin
            m_read      = ~we_q;
            m_write     = we_q;
            m_storetype = storetype_q;
            m_addr      = addr_q;
            m_wdata     = wdata_q;
         end
         S_RESP: begin
            p0_ack = ~grant_q;
            p0_err = ~grant_q & err_q;
            p1_ack = grant_q;
            p1_err = grant_q & err_q;
         end
         default: ;
      endcase
      busy         = (state_q != S_IDLE);
      timeout_flag = timeout_q;
      p0_rdata     = p0_rdata_q;
      p1_rdata     = p1_rdata_q;
   end

endmodule

`default_nettype wire

// File: tb/tb_cache_port_arbiter.sv
// ============================================================================
// tb_cache_port_arbiter : directed, table-driven bench for cache_port_arbiter
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_cache_port_arbiter;

   logic        clk;
   logic        rst;
   logic        p0_valid;
   logic [9:0]  p0_addr;
   logic        p0_ack;
   logic [31:0] p0_rdata;
   logic        p0_err;
   logic        p1_valid;
   logic        p1_we;
   logic [1:0]  p1_storetype;
   logic [9:0]  p1_addr;
   logic [31:0] p1_wdata;
   logic        p1_ack;
   logic [31:0] p1_rdata;
   logic        p1_err;
   logic        m_read;
   logic        m_write;
   logic [1:0]  m_storetype;
   logic [9:0]  m_addr;
   logic [31:0] m_wdata;
   logic        m_stall;
   logic [31:0] m_rdata;
   logic        busy;
   logic        timeout_flag;

   int checks = 0;
   int errors = 0;

   cache_port_arbiter #(.ADDR_W(10), .DATA_W(32), .MAX_WAIT(4)) dut (
      .clk(clk), .rst(rst),
      .p0_valid(p0_valid), .p0_addr(p0_addr), .p0_ack(p0_ack),
      .p0_rdata(p0_rdata), .p0_err(p0_err),
      .p1_valid(p1_valid), .p1_we(p1_we), .p1_storetype(p1_storetype),
      .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_ack(p1_ack),
      .p1_rdata(p1_rdata), .p1_err(p1_err),
      .m_read(m_read), .m_write(m_write), .m_storetype(m_storetype),
      .m_addr(m_addr), .m_wdata(m_wdata), .m_stall(m_stall),
      .m_rdata(m_rdata), .busy(busy), .timeout_flag(timeout_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        p0v, p1v, stall;
      logic [31:0] mrd;
      logic        rd, bsy, a0, a1;
      logic [9:0]  addr;
      logic [31:0] r0, r1;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input logic p0v, input logic p1v, input logic stall,
                               input logic [31:0] mrd, input logic rd, input logic bsy,
                               input logic a0, input logic a1, input logic [9:0] addr,
                               input logic [31:0] r0, input logic [31:0] r1);
      vec_t v;
      v.p0v = p0v; v.p1v = p1v; v.stall = stall; v.mrd = mrd;
      v.rd = rd; v.bsy = bsy; v.a0 = a0; v.a1 = a1; v.addr = addr;
      v.r0 = r0; v.r1 = r1;
      tbl.push_back(v);
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [127:0] all_out();
      return {12'b0, m_read, m_write, m_storetype, m_addr, m_wdata, p0_ack, p0_err,
              p0_rdata, p1_ack, p1_err, p1_rdata, busy, timeout_flag};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   localparam logic [31:0] A1 = 32'hA000_0001, A2 = 32'hA000_0002, A3 = 32'hA000_0003;
   localparam logic [31:0] B1 = 32'hB000_0001, B2 = 32'hB000_0002, B3 = 32'hB000_0003;
   localparam logic [31:0] DB = 32'hDEAD_BEEF;

   initial begin
      // Round robin from reset: p0 first, then strict alternation, one ack per port per 6 cycles
      add(1,1,0,0,  0,0,0,0,10'h000, 0, 0);
      add(1,1,0,A1, 1,1,0,0,10'h040, 0, 0);
      add(1,1,0,0,  0,1,1,0,10'h000, A1,0);
      add(1,1,0,0,  0,0,0,0,10'h000, A1,0);
      add(1,1,0,B1, 1,1,0,0,10'h100, A1,0);
      add(1,1,0,0,  0,1,0,1,10'h000, A1,B1);
      add(1,1,0,0,  0,0,0,0,10'h000, A1,B1);
      add(1,1,0,A2, 1,1,0,0,10'h040, A1,B1);
      add(1,1,0,0,  0,1,1,0,10'h000, A2,B1);
      add(1,1,0,0,  0,0,0,0,10'h000, A2,B1);
      add(1,1,0,B2, 1,1,0,0,10'h100, A2,B1);
      add(1,1,0,0,  0,1,0,1,10'h000, A2,B2);
      add(1,1,0,0,  0,0,0,0,10'h000, A2,B2);
      add(1,1,0,A3, 1,1,0,0,10'h040, A2,B2);
      add(1,1,0,0,  0,1,1,0,10'h000, A3,B2);
      add(1,1,0,0,  0,0,0,0,10'h000, A3,B2);
      add(1,1,0,B3, 1,1,0,0,10'h100, A3,B2);
      add(1,1,0,0,  0,1,0,1,10'h000, A3,B3);
      add(0,0,0,0,  0,0,0,0,10'h000, A3,B3);
      // Single p0 hit at 0x040
      add(1,0,0,0,  0,0,0,0,10'h000, A3,B3);
      add(1,0,0,DB, 1,1,0,0,10'h040, A3,B3);
      add(0,0,0,0,  0,1,1,0,10'h000, DB,B3);
      add(0,0,0,0,  0,0,0,0,10'h000, DB,B3);

      rst = 1'b0;
      p0_valid = 0; p0_addr = 10'h040;
      p1_valid = 0; p1_we = 0; p1_storetype = 2'b00; p1_addr = 10'h100; p1_wdata = '0;
      m_stall = 0; m_rdata = '0;
      #2;
      chk("in_reset", all_out(), '0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("idle_after_reset", all_out(), '0);
      end

      for (int i = 0; i < tbl.size(); i++) begin
         step();
         p0_valid = tbl[i].p0v; p1_valid = tbl[i].p1v;
         m_stall = tbl[i].stall; m_rdata = tbl[i].mrd;
         #1;
         chk($sformatf("table[%0d]", i),
             {m_read, m_write, busy, p0_ack, p0_err, p1_ack, p1_err, m_addr, p0_rdata, p1_rdata},
             {tbl[i].rd, 1'b0, tbl[i].bsy, tbl[i].a0, 1'b0, tbl[i].a1, 1'b0, tbl[i].addr,
              tbl[i].r0, tbl[i].r1});
      end

      // p1 store with three stall cycles
      step();
      p1_valid = 1; p1_we = 1; p1_addr = 10'h3FC; p1_wdata = 32'h1234_5678; p1_storetype = 2'b01;
      m_stall = 0; m_rdata = '0;
      #1 chk("store_idle", busy, 1'b0);
      for (int k = 1; k <= 4; k++) begin
         step();
         m_stall = (k < 4);
         #1;
         chk($sformatf("store_busy%0d", k),
             {m_write, m_read, m_addr, m_wdata, m_storetype, p1_ack},
             {1'b1, 1'b0, 10'h3FC, 32'h1234_5678, 2'b01, 1'b0});
      end
      step();
      p1_valid = 0; p1_we = 0; m_stall = 0;
      #1 chk("store_ack", {p1_ack, p1_err, p1_rdata, m_write, m_read, busy},
                          {1'b1, 1'b0, B3, 1'b0, 1'b0, 1'b1});
      step();
      #1 chk("store_done", {busy, p1_ack}, 2'b00);

      // p1 load with stall stuck: abort after exactly 4 BUSY cycles
      step();
      p1_valid = 1; p1_addr = 10'h200; m_stall = 1;
      #1;
      for (int k = 1; k <= 4; k++) begin
         step();
         chk($sformatf("abort_busy%0d", k), {m_read, busy, p1_ack, timeout_flag}, 4'b1100);
      end
      step();
      p1_valid = 0; m_stall = 0;
      #1 chk("abort_ack", {p1_ack, p1_err, p1_rdata, timeout_flag, m_read},
                          {1'b1, 1'b1, B3, 1'b1, 1'b0});

      // successful read afterwards keeps timeout_flag sticky
      step();
      p0_valid = 1;
      #1;
      step();
      m_rdata = 32'hCAFE_F00D;
      #1 chk("post_abort_busy", m_read, 1'b1);
      step();
      p0_valid = 0;
      #1 chk("post_abort_ack", {p0_ack, p0_err, p0_rdata, timeout_flag},
                               {1'b1, 1'b0, 32'hCAFE_F00D, 1'b1});
      step();
      #1 chk("sticky_timeout", {busy, timeout_flag}, 2'b01);

      // p0 valid held through ack: every grant is separated by an IDLE cycle
      step();
      p0_valid = 1; m_rdata = 32'h1111_2222;
      #1 chk("held_0", {busy, p0_ack}, 2'b00);
      for (int j = 1; j <= 8; j++) begin
         step();
         chk($sformatf("held_%0d", j), {busy, p0_ack}, {(j % 3) != 0, (j % 3) == 2});
      end
      step();
      p0_valid = 0;
      #1 chk("held_end", {busy, p0_ack}, 2'b00);

      // asynchronous reset in the middle of BUSY
      step();
      p0_valid = 1;
      #1;
      step();
      chk("rst_mid_busy", m_read, 1'b1);
      #2 rst = 1'b0;
      #1 chk("rst_mid_drop", all_out(), '0);
      p0_valid = 0;
      step();
      rst = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         chk($sformatf("post_rst%0d", k), all_out(), '0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
